// File: rtl/a2bus_stream_fifo_if.sv
// Apple II bus slave view shared by the capture front end and its bench.
// The single logic clock and the active-low bus reset travel on the interface.
interface a2bus_if;
    logic        clk_logic;
    logic        system_reset_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        m2sel_n;
    logic        m2b0;
    logic        sw_gs;
    logic        data_in_strobe;

    modport slave (
        input clk_logic,
        input system_reset_n,
        input addr,
        input data,
        input rw_n,
        input m2sel_n,
        input m2b0,
        input sw_gs,
        input data_in_strobe
    );
endinterface

// File: rtl/a2bus_stream_fifo.sv
// a2bus_stream_fifo: filters Apple II bus cycles through programmable address
// windows and buffers the resulting packets in a show-ahead FIFO.
// FIFO overflow is reported in-band with a marker packet that carries the
// number of captures lost since the previous marker.
// Optional feature macro: A2BUS_STREAM_TIMESTAMP_EN widens packets to 48 bits
// with a saturating cycles-since-previous-push delta in [47:32].
module a2bus_stream_fifo #(
    parameter bit ENABLE      = 1'b1,
    parameter int FIFO_DEPTH  = 16,
    parameter int NUM_WINDOWS = 4,
`ifdef A2BUS_STREAM_TIMESTAMP_EN
    localparam int PKT_W      = 48,
`else
    localparam int PKT_W      = 32,
`endif
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int IDX_W      = $clog2(NUM_WINDOWS)
) (
    a2bus_if.slave             a2bus,
    input  logic               capture_enable,
    input  logic               capture_all,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [15:0]        cfg_lo,
    input  logic [15:0]        cfg_hi,
    input  logic [1:0]         cfg_rw_sel,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic [PKT_W-1:0]   pkt_data,
    output logic [PTR_W:0]     fifo_level,
    output logic [15:0]        drop_count,
    output logic               overflow_led,
    output logic               activity_led
);

    localparam logic [PTR_W:0] DEPTH_L = FIFO_DEPTH[PTR_W:0];

    logic clk;
    logic rst_n;
    assign clk   = a2bus.clk_logic;
    assign rst_n = a2bus.system_reset_n;

    logic [15:0] win_lo_q [NUM_WINDOWS];
    logic [15:0] win_lo_d [NUM_WINDOWS];
    logic [15:0] win_hi_q [NUM_WINDOWS];
    logic [15:0] win_hi_d [NUM_WINDOWS];
    logic [1:0]  win_rw_q [NUM_WINDOWS];
    logic [1:0]  win_rw_d [NUM_WINDOWS];

    logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [15:0]      drop_q, drop_d;
    logic [7:0]       pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             act_q, act_d;
    logic             start_q, start_d;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             qualified;
    logic             capture;
    logic             full;
    logic             pop;
    logic             push;
    logic             marker;
    logic             drop;
    logic [PKT_W-1:0] push_pkt;

`ifdef A2BUS_STREAM_TIMESTAMP_EN
    logic [15:0] delta_q, delta_d, delta_inc;

    // Saturating cycle count since the last push.
    always_comb begin
        delta_inc = (delta_q == 16'hFFFF) ? delta_q : delta_q + 16'd1;
        delta_d   = push ? 16'd0 : delta_inc;
    end

    // Delta counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) delta_q <= 16'd0;
        else        delta_q <= delta_d;
    end
`endif

    // Window programming; a write becomes visible in the following cycle.
    always_comb begin
        win_lo_d = win_lo_q;
        win_hi_d = win_hi_q;
        win_rw_d = win_rw_q;
        if (cfg_we) begin
            win_lo_d[cfg_idx] = cfg_lo;
            win_hi_d[cfg_idx] = cfg_hi;
            win_rw_d[cfg_idx] = cfg_rw_sel;
        end
    end

    // Window compare; scanning downwards leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_WINDOWS - 1; k >= 0; k--) begin
            if ((win_lo_q[k] <= a2bus.addr) && (a2bus.addr <= win_hi_q[k]) &&
                ((a2bus.rw_n && win_rw_q[k][0]) || (!a2bus.rw_n && win_rw_q[k][1]))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // Push arbitration: startup packet, then pending overflow marker, then capture.
    // A capture that loses arbitration or finds the FIFO full is counted as dropped.
    always_comb begin
        qualified = ENABLE && capture_enable && a2bus.data_in_strobe && !a2bus.m2sel_n;
        capture   = qualified && (capture_all || hit);
        full      = (level_q == DEPTH_L);
        pop       = pkt_valid && pkt_ready;
        push      = 1'b0;
        marker    = 1'b0;
        drop      = 1'b0;
        push_pkt  = '0;
        if (start_q) begin
            push         = 1'b1;
            push_pkt[0]  = 1'b1;
            drop         = capture;
        end else if (ovf_q && !full) begin
            push            = 1'b1;
            marker          = 1'b1;
            push_pkt[31:0]  = {16'hFFFF, pend_q, 8'h02};
            drop            = capture;
        end else if (capture) begin
            if (full) begin
                drop = 1'b1;
            end else begin
                push           = 1'b1;
                push_pkt[31:0] = {a2bus.addr, a2bus.data, a2bus.rw_n, a2bus.m2sel_n,
                                  a2bus.m2b0, a2bus.sw_gs,
                                  (capture_all ? 2'b00 : 2'(hit_idx)), 2'b00};
            end
        end
`ifdef A2BUS_STREAM_TIMESTAMP_EN
        push_pkt[47:32] = start_q ? 16'd0 : delta_inc;
`endif
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
        drop_d   = drop_q;
        pend_d   = marker ? 8'd0 : pend_q;
        ovf_d    = marker ? 1'b0 : ovf_q;
        if (drop) begin
            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
            pend_d = (pend_d == 8'hFF) ? pend_d : pend_d + 8'd1;
            ovf_d  = 1'b1;
        end
        act_d    = push;
        start_d  = 1'b0;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 16'd0;
            pend_q   <= 8'd0;
            ovf_q    <= 1'b0;
            act_q    <= 1'b0;
            start_q  <= 1'b1;
            for (int k = 0; k < NUM_WINDOWS; k++) begin
                win_lo_q[k] <= 16'd0;
                win_hi_q[k] <= 16'd0;
                win_rw_q[k] <= 2'b00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            act_q    <= act_d;
            start_q  <= start_d;
            win_lo_q <= win_lo_d;
            win_hi_q <= win_hi_d;
            win_rw_q <= win_rw_d;
        end
    end

    // Packet storage; contents are meaningless until covered by the level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_pkt;
    end

    assign pkt_valid    = (level_q != '0);
    assign pkt_data     = pkt_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level   = level_q;
    assign drop_count   = drop_q;
    assign overflow_led = ovf_q;
    assign activity_led = act_q;

endmodule

// File: tb/tb_a2bus_stream_fifo.sv
// Directed self-checking bench for a2bus_stream_fifo (default 16-deep, 4 windows).
module tb_a2bus_stream_fifo;

`ifdef A2BUS_STREAM_TIMESTAMP_EN
    localparam int PKT_W = 48;
`else
    localparam int PKT_W = 32;
`endif

    a2bus_if bus ();

    logic             capture_enable;
    logic             capture_all;
    logic             cfg_we;
    logic [1:0]       cfg_idx;
    logic [15:0]      cfg_lo;
    logic [15:0]      cfg_hi;
    logic [1:0]       cfg_rw_sel;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [PKT_W-1:0] pkt_data;
    logic [4:0]       fifo_level;
    logic [15:0]      drop_count;
    logic             overflow_led;
    logic             activity_led;

    int n_cmp = 0;
    int n_err = 0;

    a2bus_stream_fifo dut (
        .a2bus          (bus.slave),
        .capture_enable (capture_enable),
        .capture_all    (capture_all),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_lo         (cfg_lo),
        .cfg_hi         (cfg_hi),
        .cfg_rw_sel     (cfg_rw_sel),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_data       (pkt_data),
        .fifo_level     (fifo_level),
        .drop_count     (drop_count),
        .overflow_led   (overflow_led),
        .activity_led   (activity_led)
    );

    initial bus.clk_logic = 1'b0;
    always #5 bus.clk_logic = ~bus.clk_logic;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] cap_pkt(input logic [15:0] a, input logic [7:0] d,
                                            input logic rw, input logic b0, input logic gs,
                                            input logic [1:0] idx);
        return {a, d, rw, 1'b0, b0, gs, idx, 2'b00};
    endfunction

    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                             input logic rw, input logic b0, input logic gs);
        bus.addr = a; bus.data = d; bus.rw_n = rw; bus.m2b0 = b0; bus.sw_gs = gs;
        bus.data_in_strobe = 1'b1;
        @(negedge bus.clk_logic);
        bus.data_in_strobe = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] lo,
                             input logic [15:0] hi, input logic [1:0] rw);
        cfg_idx = idx; cfg_lo = lo; cfg_hi = hi; cfg_rw_sel = rw; cfg_we = 1'b1;
        @(negedge bus.clk_logic);
        cfg_we = 1'b0;
    endtask

    task automatic drain;
        pkt_ready = 1'b1;
        for (int i = 0; i < 40 && fifo_level != 0; i++) @(negedge bus.clk_logic);
        pkt_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.system_reset_n = 1'b0;
        repeat (3) @(negedge bus.clk_logic);
        n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", pkt_valid); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        n_cmp++; if (pkt_data !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", pkt_data); end
        n_cmp++; if ({drop_count, overflow_led, activity_led} !== 18'd0) begin n_err++;
            $display("FAIL rst_status: drop %h ovf %b act %b want all 0", drop_count, overflow_led, activity_led); end
        bus.system_reset_n = 1'b1;
        #1;
        n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL start_early: valid %b want 0", pkt_valid); end
        @(negedge bus.clk_logic);
        n_cmp++; if (pkt_valid !== 1'b1 || pkt_data[31:0] !== 32'h0000_0001) begin n_err++;
            $display("FAIL start_pkt: valid %b data %h want 1 / 00000001", pkt_valid, pkt_data); end
        n_cmp++; if (fifo_level !== 5'd1 || activity_led !== 1'b1) begin n_err++;
            $display("FAIL start_level: level %0d act %b want 1 / 1", fifo_level, activity_led); end
`ifdef A2BUS_STREAM_TIMESTAMP_EN
        n_cmp++; if (pkt_data[47:32] !== 16'd0) begin n_err++; $display("FAIL start_delta: got %h want 0", pkt_data[47:32]); end
`endif
        @(negedge bus.clk_logic);
        n_cmp++; if (activity_led !== 1'b0 || fifo_level !== 5'd1) begin n_err++;
            $display("FAIL start_idle: act %b level %0d want 0 / 1", activity_led, fifo_level); end
        drain;
    endtask

    task automatic test_window;
        cfg_write(2'd0, 16'hC03C, 16'hC03F, 2'b11);
        bus_cycle(16'hC03D, 8'h5A, 1'b0, 1'b0, 1'b0);
        bus_cycle(16'hC030, 8'h11, 1'b0, 1'b0, 1'b0);
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL win0_level: got %0d want 1", fifo_level); end
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'hC03D, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0)) begin n_err++;
            $display("FAIL win0_pkt: got %h want %h", pkt_data[31:0], cap_pkt(16'hC03D, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0)); end
        drain;
        // Upper bound is inclusive, one past it is not.
        bus_cycle(16'hC03F, 8'h22, 1'b1, 1'b0, 1'b0);
        bus_cycle(16'hC040, 8'h23, 1'b1, 1'b0, 1'b0);
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd1 || pkt_data[31:0] !== cap_pkt(16'hC03F, 8'h22, 1'b1, 1'b0, 1'b0, 2'd0)) begin n_err++;
            $display("FAIL win0_edge: level %0d data %h", fifo_level, pkt_data[31:0]); end
        drain;
    endtask

    task automatic test_window_bounds;
        cfg_write(2'd1, 16'h2000, 16'h1FFF, 2'b11);
        bus_cycle(16'h2000, 8'h33, 1'b1, 1'b0, 1'b0);
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL win_inverted: level %0d want 0", fifo_level); end
        cfg_write(2'd1, 16'h2000, 16'h20FF, 2'b01);
        bus_cycle(16'h2000, 8'h44, 1'b0, 1'b0, 1'b0);
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL win_rdonly_write: level %0d want 0", fifo_level); end
        bus_cycle(16'h2000, 8'h33, 1'b1, 1'b1, 1'b1);
        @(negedge bus.clk_logic);
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h2000, 8'h33, 1'b1, 1'b1, 1'b1, 2'd1)) begin n_err++;
            $display("FAIL win1_read: got %h want %h", pkt_data[31:0], cap_pkt(16'h2000, 8'h33, 1'b1, 1'b1, 1'b1, 2'd1)); end
        drain;
        // Overlapping windows 1 and 3: the lower index wins.
        cfg_write(2'd3, 16'h2000, 16'h2000, 2'b01);
        bus_cycle(16'h2000, 8'h55, 1'b1, 1'b0, 1'b0);
        cfg_write(2'd1, 16'h0000, 16'h0000, 2'b00);
        bus_cycle(16'h2000, 8'h66, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h2000, 8'h55, 1'b1, 1'b0, 1'b0, 2'd1)) begin n_err++;
            $display("FAIL win_lowest: got %h", pkt_data[31:0]); end
        pkt_ready = 1'b1; @(negedge bus.clk_logic); pkt_ready = 1'b0;
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h2000, 8'h66, 1'b1, 1'b0, 1'b0, 2'd3)) begin n_err++;
            $display("FAIL win3: got %h", pkt_data[31:0]); end
        drain;
    endtask

    task automatic test_qualify;
        capture_all = 1'b1;
        bus_cycle(16'h1234, 8'h77, 1'b0, 1'b0, 1'b0);
        bus_cycle(16'h2000, 8'h88, 1'b1, 1'b0, 1'b0);
        capture_enable = 1'b0;
        bus_cycle(16'h3333, 8'h01, 1'b0, 1'b0, 1'b0);
        capture_enable = 1'b1;
        bus.m2sel_n = 1'b1;
        bus_cycle(16'h4444, 8'h02, 1'b0, 1'b0, 1'b0);
        bus.m2sel_n = 1'b0;
        n_cmp++; if (fifo_level !== 5'd2) begin n_err++; $display("FAIL qual_level: got %0d want 2", fifo_level); end
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h1234, 8'h77, 1'b0, 1'b0, 1'b0, 2'd0)) begin n_err++;
            $display("FAIL all_pkt0: got %h", pkt_data[31:0]); end
        pkt_ready = 1'b1; @(negedge bus.clk_logic); pkt_ready = 1'b0;
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h2000, 8'h88, 1'b1, 1'b0, 1'b0, 2'd0)) begin n_err++;
            $display("FAIL all_pkt1: got %h", pkt_data[31:0]); end
        drain;
        capture_all = 1'b0;
    endtask

    task automatic test_overflow;
        capture_all = 1'b1;
        for (int i = 0; i < 20; i++) bus_cycle(16'h0100 + 16'(i), 8'(i), 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
        n_cmp++; if (drop_count !== 16'd4) begin n_err++; $display("FAIL ovf_drops: got %0d want 4", drop_count); end
        n_cmp++; if (overflow_led !== 1'b1) begin n_err++; $display("FAIL ovf_led: got %b want 1", overflow_led); end
        n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0)) begin n_err++;
            $display("FAIL ovf_head: got %h", pkt_data[31:0]); end
        pkt_ready = 1'b1; @(negedge bus.clk_logic); pkt_ready = 1'b0;
        n_cmp++; if (fifo_level !== 5'd15) begin n_err++; $display("FAIL ovf_pop: level %0d want 15", fifo_level); end
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd16 || overflow_led !== 1'b0) begin n_err++;
            $display("FAIL marker_push: level %0d led %b want 16 / 0", fifo_level, overflow_led); end
        pkt_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            n_cmp++; if (pkt_data[31:0] !== cap_pkt(16'h0100 + 16'(i), 8'(i), 1'b0, 1'b0, 1'b0, 2'd0)) begin n_err++;
                $display("FAIL ovf_entry%0d: got %h", i, pkt_data[31:0]); end
            @(negedge bus.clk_logic);
        end
        n_cmp++; if (pkt_data[31:0] !== 32'hFFFF_0402) begin n_err++; $display("FAIL marker: got %h want FFFF0402", pkt_data[31:0]); end
        @(negedge bus.clk_logic);
        pkt_ready = 1'b0;
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL ovf_empty: level %0d want 0", fifo_level); end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 16; i++) bus_cycle(16'h0200 + 16'(i), 8'(i), 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fifo_level !== 5'd16 || overflow_led !== 1'b0) begin n_err++;
            $display("FAIL fpp_fill: level %0d led %b want 16 / 0", fifo_level, overflow_led); end
        pkt_ready = 1'b1;
        bus_cycle(16'h02FF, 8'hEE, 1'b0, 1'b0, 1'b0);
        pkt_ready = 1'b0;
        n_cmp++; if (fifo_level !== 5'd15) begin n_err++; $display("FAIL fpp_level: got %0d want 15", fifo_level); end
        n_cmp++; if (drop_count !== 16'd5 || overflow_led !== 1'b1) begin n_err++;
            $display("FAIL fpp_drop: drops %0d led %b want 5 / 1", drop_count, overflow_led); end
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL fpp_marker_level: got %0d want 16", fifo_level); end
        pkt_ready = 1'b1;
        for (int i = 1; i < 16; i++) @(negedge bus.clk_logic);
        n_cmp++; if (pkt_data[31:0] !== 32'hFFFF_0102) begin n_err++; $display("FAIL fpp_marker: got %h want FFFF0102", pkt_data[31:0]); end
        @(negedge bus.clk_logic);
        pkt_ready = 1'b0;
        capture_all = 1'b0;
    endtask

    task automatic test_reset_mid;
        capture_all = 1'b1;
        bus_cycle(16'h0300, 8'h01, 1'b0, 1'b0, 1'b0);
        bus_cycle(16'h0301, 8'h02, 1'b0, 1'b0, 1'b0);
        capture_all = 1'b0;
        #2 bus.system_reset_n = 1'b0;
        #1;
        n_cmp++; if (fifo_level !== 5'd0 || pkt_valid !== 1'b0 || drop_count !== 16'd0) begin n_err++;
            $display("FAIL mid_reset: level %0d valid %b drops %0d want 0", fifo_level, pkt_valid, drop_count); end
        @(negedge bus.clk_logic);
        bus.system_reset_n = 1'b1;
        @(negedge bus.clk_logic);
        n_cmp++; if (pkt_data[31:0] !== 32'h0000_0001 || fifo_level !== 5'd1) begin n_err++;
            $display("FAIL mid_restart: data %h level %0d", pkt_data[31:0], fifo_level); end
        drain;
        bus_cycle(16'hC03D, 8'h5A, 1'b0, 1'b0, 1'b0);
        @(negedge bus.clk_logic);
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL mid_win_off: level %0d want 0", fifo_level); end
    endtask

`ifdef A2BUS_STREAM_TIMESTAMP_EN
    task automatic test_timestamp;
        capture_all = 1'b1;
        bus_cycle(16'h0400, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (99) @(negedge bus.clk_logic);
        bus_cycle(16'h0401, 8'h02, 1'b0, 1'b0, 1'b0);
        capture_all = 1'b0;
        pkt_ready = 1'b1; @(negedge bus.clk_logic); pkt_ready = 1'b0;
        n_cmp++; if (pkt_data[47:32] !== 16'h0064) begin n_err++; $display("FAIL ts_delta: got %h want 0064", pkt_data[47:32]); end
        drain;
    endtask
`endif

    initial begin
        bus.system_reset_n = 1'b0;
        bus.addr = 16'd0; bus.data = 8'd0; bus.rw_n = 1'b1; bus.m2sel_n = 1'b0;
        bus.m2b0 = 1'b0; bus.sw_gs = 1'b0; bus.data_in_strobe = 1'b0;
        capture_enable = 1'b1; capture_all = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0;
        cfg_lo = 16'd0; cfg_hi = 16'd0; cfg_rw_sel = 2'b00; pkt_ready = 1'b0;
        test_reset;
        test_window;
        test_window_bounds;
        test_qualify;
        test_overflow;
        test_full_push_pop;
        test_reset_mid;
`ifdef A2BUS_STREAM_TIMESTAMP_EN
        test_timestamp;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
